// File: rtl/siggen_pkg.sv
// Shared definitions for the signal-generator delay path.
package siggen_pkg;

  localparam int unsigned SIGGEN_A_WIDTH = 8;
  localparam int unsigned SIGGEN_D_WIDTH = 8;

  typedef enum logic {FILL, RUN} dly_state_t;

  // Source of the delay buffer output register stage.
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_BYP} dly_sel_t;

endpackage

// File: rtl/delay_buffer_ram2port.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module ram2port
  import siggen_pkg::*;
#(
  parameter int unsigned A_WIDTH = SIGGEN_A_WIDTH,
  parameter int unsigned D_WIDTH = SIGGEN_D_WIDTH
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] din,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] dout
);

  logic [D_WIDTH-1:0] mem [0:(1<<A_WIDTH)-1];
  logic [D_WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // Registered read port; holds when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign dout = rd_data_q;

endmodule

// File: rtl/delay_buffer.sv
// Circular delay line: writes every strobed sample, reads back the sample
// written `offset` strobes earlier. Refills after every offset change.
// Optional macro DELAY_BUFFER_ZERO_FILL_EN: emit zero-valued valid samples
// while refilling so the output stream stays continuous.
module delay_buffer
  import siggen_pkg::*;
#(
  parameter int unsigned A_WIDTH = SIGGEN_A_WIDTH,
  parameter int unsigned D_WIDTH = SIGGEN_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [A_WIDTH-1:0] offset,
  input  logic [D_WIDTH-1:0] din,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               primed
);

  localparam logic [A_WIDTH:0] FILL_MAX = {1'b1, {A_WIDTH{1'b0}}};

  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] offset_q;
  logic [A_WIDTH:0]   fill_cnt_q, fill_cnt_d;
  dly_state_t         state_q, state_d;
  dly_sel_t           sel_q, sel_d;
  logic [D_WIDTH-1:0] byp_q, byp_d;
  logic               valid_q, valid_d;
  logic               primed_q, primed_d;

  logic [A_WIDTH-1:0] rd_addr;
  logic [A_WIDTH:0]   fill_inc;
  logic [D_WIDTH-1:0] ram_dout;
  logic               off_chg;
  logic               issue_read;
  logic               bypass;
  logic               zero_out;

  assign off_chg    = (offset != offset_q);
  assign rd_addr    = wr_ptr_q - offset_q;
  assign issue_read = en && (state_q == RUN) && !off_chg;
  assign bypass     = (rd_addr == wr_ptr_q);
  assign fill_inc   = (fill_cnt_q == FILL_MAX) ? fill_cnt_q
                                               : fill_cnt_q + (A_WIDTH+1)'(1);

`ifdef DELAY_BUFFER_ZERO_FILL_EN
  assign zero_out = en && !issue_read;
`else
  assign zero_out = 1'b0;
`endif

  ram2port #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (en),
    .wr_addr (wr_ptr_q),
    .din     (din),
    .rd_en   (issue_read && !bypass),
    .rd_addr (rd_addr),
    .dout    (ram_dout)
  );

  // Next-state: write pointer, refill tracking and output source selection.
  always_comb begin
    wr_ptr_d   = en ? wr_ptr_q + A_WIDTH'(1) : wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    state_d    = state_q;
    primed_d   = primed_q;
    sel_d      = sel_q;
    byp_d      = byp_q;
    valid_d    = issue_read || zero_out;

    // Zero offset reads the slot being written this cycle; the RAM returns
    // old data there, so the incoming sample is captured directly instead.
    // The output mux selects between RAM register and this capture register,
    // and the selection only moves on an emitted sample so dout holds otherwise.
    if (issue_read) begin
      if (bypass) begin
        sel_d = SEL_BYP;
        byp_d = din;
      end else begin
        sel_d = SEL_RAM;
      end
    end else if (zero_out) begin
      sel_d = SEL_ZERO;
    end

    if (off_chg) begin
      fill_cnt_d = '0;
      state_d    = FILL;
      primed_d   = 1'b0;
    end else if (en && (state_q == FILL)) begin
      fill_cnt_d = fill_inc;
      if (fill_inc >= {1'b0, offset_q}) begin
        state_d  = RUN;
        primed_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      offset_q   <= '0;
      fill_cnt_q <= '0;
      state_q    <= FILL;
      sel_q      <= SEL_ZERO;
      byp_q      <= '0;
      valid_q    <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      offset_q   <= offset;
      fill_cnt_q <= fill_cnt_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      byp_q      <= byp_d;
      valid_q    <= valid_d;
      primed_q   <= primed_d;
    end
  end

  // Output mux over registered sources.
  always_comb begin
    dout = '0;
    case (sel_q)
      SEL_RAM: dout = ram_dout;
      SEL_BYP: dout = byp_q;
      default: dout = '0;
    endcase
  end

  assign dout_valid = valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_delay_buffer.sv
// Testbench for delay_buffer (small A_WIDTH=4 instance to exercise wrap).
module tb_delay_buffer;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 16;
`ifdef DELAY_BUFFER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          primed;

  always #5 clk = ~clk;

  delay_buffer #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .offset     (offset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sample history plus "writes since last offset change".
  int            m_off;
  int            m_fill;
  bit            m_run;
  bit            m_primed;
  bit            m_valid;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] hist[$];

  function automatic void model_reset();
    m_off = 0; m_fill = 0; m_run = 0; m_primed = 0; m_valid = 0; m_dout = '0;
    hist.delete();
  endfunction

  function automatic void model_step(bit e, int off, logic [DW-1:0] d);
    if (e) begin
      hist.push_back(d);
      if (hist.size() > 64) void'(hist.pop_front());
    end
    if (off != m_off) begin
      m_off = off; m_fill = 0; m_run = 0; m_primed = 0;
      m_valid = e && ZF;
      if (e && ZF) m_dout = '0;
    end else if (!e) begin
      m_valid = 0;
    end else if (m_run) begin
      m_dout  = hist[hist.size() - 1 - m_off];
      m_valid = 1;
    end else begin
      if (m_fill < DEPTH) m_fill = m_fill + 1;
      if (m_fill >= m_off) begin m_run = 1; m_primed = 1; end
      m_valid = ZF;
      if (ZF) m_dout = '0;
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit e, int off, logic [DW-1:0] d, bit chk);
    en = e; offset = AW'(off); din = d;
    @(posedge clk);
    model_step(e, off, d);
    #1;
    if (chk) begin
      check("model_dout",   dout,       m_dout);
      check("model_valid",  dout_valid, m_valid);
      check("model_primed", primed,     m_primed);
    end
  endtask

  task automatic do_reset();
    en = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    bit            en;
    int            off;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    bit            valid;
    bit            primed;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Basic delay table, offset 4: primed after 4th write, then dout = din-4.
    tbl[0] = '{0, 4, 8'd0, 8'd0, 0,  0};
    tbl[1] = '{1, 4, 8'd0, 8'd0, ZF, 0};
    tbl[2] = '{1, 4, 8'd1, 8'd0, ZF, 0};
    tbl[3] = '{1, 4, 8'd2, 8'd0, ZF, 0};
    tbl[4] = '{1, 4, 8'd3, 8'd0, ZF, 1};
    tbl[5] = '{1, 4, 8'd4, 8'd0, 1,  1};
    tbl[6] = '{1, 4, 8'd5, 8'd1, 1,  1};
    tbl[7] = '{1, 4, 8'd6, 8'd2, 1,  1};
    tbl[8] = '{0, 4, 8'd7, 8'd2, 0,  1};
    tbl[9] = '{1, 4, 8'd7, 8'd3, 1,  1};

    // Reset state.
    rst_n = 0;
    model_reset();
    #1;
    check("reset_dout",   dout,       0);
    check("reset_valid",  dout_valid, 0);
    check("reset_primed", primed,     0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1. Basic delay.
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].en, tbl[i].off, tbl[i].din, 1'b0);
      check($sformatf("tbl%0d_dout", i),   dout,       tbl[i].dout);
      check($sformatf("tbl%0d_valid", i),  dout_valid, tbl[i].valid);
      check($sformatf("tbl%0d_primed", i), primed,     tbl[i].primed);
    end

    // 2. Gapped strobe, offset 3.
    do_reset();
    tick(0, 3, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick(i % 2 == 0, 3, 8'(8'h30 + i), 1'b1);
      if (i % 2 == 1) check("gap_no_valid", dout_valid, 0);
    end

    // 3. Wrap-around, offset 5 over 40 strobes.
    do_reset();
    tick(0, 5, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick(1, 5, 8'(i), 1'b1);
      if (i >= 5) begin
        check("wrap_dout",  dout,       i - 5);
        check("wrap_valid", dout_valid, 1);
      end
    end

    // 4. Offset change 4 -> 2 while running.
    do_reset();
    tick(0, 4, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) tick(1, 4, 8'(100 + i), 1'b1);
    tick(1, 2, 8'd200, 1'b1);
    check("chg_primed0", primed,     0);
    check("chg_valid0",  dout_valid, ZF);
    tick(1, 2, 8'd201, 1'b1);
    check("chg_valid1",  dout_valid, ZF);
    tick(1, 2, 8'd202, 1'b1);
    check("chg_valid2",  dout_valid, ZF);
    check("chg_primed2", primed,     1);
    tick(1, 2, 8'd203, 1'b1);
    check("chg_dout",    dout,       201);
    check("chg_valid3",  dout_valid, 1);

    // 5. Zero offset: write-first bypass.
    do_reset();
    tick(0, 0, 8'h00, 1'b1);
    tick(1, 0, 8'h11, 1'b1);
    tick(1, 0, 8'hA5, 1'b1);
    check("zero_dout",  dout,       8'hA5);
    check("zero_valid", dout_valid, 1);
    tick(1, 0, 8'h5A, 1'b1);
    check("zero_dout2", dout,       8'h5A);

    // 6. Async reset mid-cycle while running.
    #2 rst_n = 0;
    #1;
    check("areset_dout",   dout,       0);
    check("areset_valid",  dout_valid, 0);
    check("areset_primed", primed,     0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    tick(1, 0, 8'h77, 1'b1);
    check("refill_valid", dout_valid, ZF);
    tick(1, 0, 8'h78, 1'b1);
    check("refill_dout",  dout,       8'h78);

    // Randomized traffic against the model.
    do_reset();
    begin
      int off_r;
      off_r = 0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 19) == 0) off_r = int'($urandom_range(0, DEPTH - 1));
        tick($urandom_range(0, 9) < 7, off_r, 8'($urandom), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_buffer.md
Name: delay_buffer

Overview:
- Consumer for the address-counter/sample stream in the signal generator.
- Each strobed input sample is written into a circular dual-port RAM; the write pointer is a +1 counter.
- The block reads back the sample written `offset` strobes earlier, producing a delayed copy of the waveform for a second channel.
- Sits between the sine ROM output and the second DAC/scope channel.

Parameters:
- A_WIDTH, 8, address width; buffer depth is 2**A_WIDTH samples.
- D_WIDTH, 8, sample width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; one sample written per cycle with en=1.
- offset  input  A_WIDTH  delay in samples (0 to 2**A_WIDTH-1).
- din  input  D_WIDTH  incoming sample.
- dout  output  D_WIDTH  delayed sample, registered.
- dout_valid  output  1  one-cycle pulse: dout updated this cycle.
- primed  output  1  buffer holds at least `offset` samples since the last refill.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, fill_cnt=0, offset_q=0, state=FILL.
  - dout=0, dout_valid=0, primed=0.
  - RAM contents are not cleared.
- Write path, on en=1:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1, wrapping modulo 2**A_WIDTH (all-ones to 0, no flag).
- Read address: rd_addr = wr_ptr - offset_q, modulo 2**A_WIDTH, unsigned wrap.
- Read latency:
  - The read is performed in the en cycle.
  - dout and dout_valid update on the following edge (latency 1).
- offset_q: registered copy of offset.
  - If offset != offset_q in any cycle: offset_q <= offset, fill_cnt <= 0, state <= FILL, primed <= 0.
  - This cycle's en write still occurs; its read is suppressed.
- State FILL:
  - On each en, fill_cnt <= fill_cnt+1.
  - fill_cnt is A_WIDTH+1 bits and saturates at 2**A_WIDTH.
  - Move to RUN when (fill_cnt+1) >= offset_q on an en cycle.
  - primed=1 from the following cycle.
  - The read in that transitioning en cycle is not issued.
- State RUN:
  - Every en issues a read; next cycle dout=mem[rd_addr], dout_valid=1.
  - Stays in RUN until an offset change or reset.
- offset_q=0:
  - FILL exits on the first en.
  - In RUN, read and write hit the same address; dout must equal that cycle's din (write-first bypass).
- en=0: no write, no read, pointers hold, dout holds, dout_valid=0.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously.

Optional Feature:
- Macro DELAY_BUFFER_ZERO_FILL_EN.
- Defined: in FILL, every en still produces dout_valid=1 next cycle with dout=0, so the output stream is continuous (silence during refill).
- Undefined: no dout_valid in FILL, and dout holds its last value.
- primed behaves the same either way.

Decomposition:
- Shared package siggen_pkg:
  - default A_WIDTH/D_WIDTH constants.
  - typedef enum logic {FILL, RUN} dly_state_t.
- Sub-module ram2port (parameters A_WIDTH, D_WIDTH):
  - one write port (wr_en, wr_addr, din).
  - one registered read port (rd_en, rd_addr, dout).
- Write-first bypass for equal addresses lives in delay_buffer, not in the RAM.

Test Plan:
1. Basic delay:
   - Stimulus: reset, offset=4, en=1 continuously, din=0,1,2,...
   - Required: primed rises after the 4th write; first dout_valid carries 0, then dout tracks din-4 every cycle.
2. Gapped strobe:
   - Stimulus: offset=3, en toggling 1,0,1,0.
   - Required: dout_valid only the cycle after each en; pointers and dout hold through en=0 cycles.
3. Wrap-around:
   - Stimulus: A_WIDTH=4, offset=5, run 40 strobes.
   - Required: dout stays din-5 across the wr_ptr 15→0 transition; no glitch.
4. Offset change mid-run:
   - Stimulus: in RUN with offset=4, switch to offset=2.
   - Required: primed=0 next cycle, no dout_valid for 2 strobes, then dout=din-2.
   - With DELAY_BUFFER_ZERO_FILL_EN: dout=0 with valid during those strobes.
5. Zero offset:
   - Stimulus: offset=0, din=8'hA5 with en=1.
   - Required: next cycle dout=8'hA5, dout_valid=1.
6. Async reset:
   - Stimulus: assert rst_n=0 mid-cycle while in RUN.
   - Required: dout=0, dout_valid=0, primed=0 before the next clock edge; refill needed after release.
